uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path; the planned transmitter reuses the same constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_LO  = 7;
   localparam int SAMPLE_MID = 8;
   localparam int SAMPLE_HI  = 9;
   localparam int DATA_BITS  = 8;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-cycle tick every TICK_DIV clocks, restartable so a
// new frame lines its sampling grid up with the detected start edge.
module uart_baud_tick #(
   parameter int TICK_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST) && !restart;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (restart || count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote, delivering bytes
// to the control unit only while rx_enable is high.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_enable,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_error,
   output logic       rx_busy
);

   localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

   if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_oversample
      $error("uart_rx: OVERSAMPLE must be 16");
   end
   if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("uart_rx: CLK_FREQ too low for BAUD_RATE*16 (TICK_DIV < 2)");
   end

   state_t      state, state_next;
   logic        rx_meta, rxs;
   logic        armed;
   logic        restart, tick, decide, vote;
   logic        deliver, stop_fail;
   logic [3:0]  s;
   logic [1:0]  votes;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;

   uart_baud_tick #(.TICK_DIV(TICK_DIV)) baud (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   assign decide  = tick && (s == 4'(SAMPLE_HI));
   assign vote    = majority3(votes[0], votes[1], rxs);
   assign rx_busy = (state == START) || (state == DATA) || (state == STOP);

   // Synchronizer presets high so reset looks like an idle line. armed requires a
   // high line after rx_enable rises, so a frame already in flight is never picked up mid-way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         armed   <= 1'b0;
         state   <= IDLE;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
         armed   <= rx_enable && (armed || rxs);
         state   <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      restart    = 1'b0;
      deliver    = 1'b0;
      stop_fail  = 1'b0;
      case (state)
         IDLE: begin
            if (rx_enable && armed && !rxs) begin
               state_next = START;
               restart    = 1'b1;
            end
         end
         START: begin
            if (decide) state_next = vote ? IDLE : DATA;
         end
         DATA: begin
            if (decide && bit_idx == 3'(DATA_BITS - 1)) state_next = STOP;
         end
         STOP: begin
            if (decide) begin
               state_next = vote ? IDLE : WAIT_IDLE;
               deliver    = vote && rx_enable;
               stop_fail  = !vote;
            end
         end
         WAIT_IDLE: begin
            if (rxs) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Sample counter, vote capture and data shift; the output pulses are registered one
   // cycle after the stop-bit decision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s           <= '0;
         votes       <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         rx_valid    <= deliver;
         frame_error <= stop_fail;
         if (restart) begin
            s <= '0;
         end else if (tick) begin
            s <= s + 1'b1;
         end
         if (tick && s == 4'(SAMPLE_LO))  votes[0] <= rxs;
         if (tick && s == 4'(SAMPLE_MID)) votes[1] <= rxs;
         if (state == START && decide) bit_idx <= '0;
         if (state == DATA && decide) begin
            shift   <= {vote, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
         if (deliver) rx_data <= shift;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven cycle by cycle at 160 clocks per bit and
// delivered bytes are checked against a queue of expected bytes.
module tb_uart_rx;

   localparam int CLK_FREQ     = 1_600_000;
   localparam int BAUD_RATE    = 10_000;
   localparam int BIT_CYCLES   = 160;
   localparam int FRAME_CYCLES = 10 * BIT_CYCLES;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_enable;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       rx_busy;

   int tests = 0;
   int failures = 0;
   int cycle = 0;
   int frame_start = 0;
   int latency = 0;
   int valid_seen = 0;
   int exp_valid = 0;
   int fe_seen = 0;
   int exp_fe = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_byte = 8'h00;
   logic prev_valid = 1'b0;
   logic prev_fe = 1'b0;

   uart_rx #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .OVERSAMPLE (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .rx_enable   (rx_enable),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .frame_error (frame_error),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic expectByte(input logic [7:0] b);
      exp_q.push_back(b);
      exp_valid++;
      last_byte = b;
   endtask

   // Output monitor: pops the scoreboard on every delivered byte and polices pulse widths.
   always @(negedge clk) begin
      if (rx_valid) begin
         valid_seen++;
         latency = cycle - frame_start;
         checkOutput("valid_width", 32'(prev_valid), 32'd0);
         checkOutput("valid_with_ferr", 32'(frame_error), 32'd0);
         checkOutput("unexpected_valid", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) checkOutput("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (frame_error) begin
         fe_seen++;
         checkOutput("ferr_width", 32'(prev_fe), 32'd0);
      end
      prev_valid = rx_valid;
      prev_fe    = frame_error;
   end

   task automatic idleLine(input logic level, input int n);
      @(posedge clk); #1;
      rx = level;
      repeat (n) @(posedge clk);
   endtask

   // One full 8N1 frame; optional one-cycle glitch, rx_enable drop and mid-frame reset.
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int glitch_at,
                                input int en_off_at, input int rst_at);
      logic level;
      for (int c = 0; c < FRAME_CYCLES; c++) begin
         @(posedge clk); #1;
         if (c == 0) frame_start = cycle;
         if (c < BIT_CYCLES) level = 1'b0;
         else if (c < 9 * BIT_CYCLES) level = data[c / BIT_CYCLES - 1];
         else level = stop_bit;
         rx = (c == glitch_at) ? ~level : level;
         if (c == en_off_at) rx_enable = 1'b0;
         if (rst_at >= 0 && c == rst_at) begin
            rst = 1'b1;
            #1;
            checkOutput("async_rst_busy", 32'(rx_busy), 32'd0);
            checkOutput("async_rst_data", 32'(rx_data), 32'd0);
            checkOutput("async_rst_valid", 32'(rx_valid), 32'd0);
            last_byte = 8'h00;
         end
         if (rst_at >= 0 && c == rst_at + 3) rst = 1'b0;
      end
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
      checkOutput("drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      rx        = 1'b1;
      rx_enable = 1'b1;
      #23;
      checkOutput("reset_data", 32'(rx_data), 32'd0);
      checkOutput("reset_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset_ferr", 32'(frame_error), 32'd0);
      checkOutput("reset_busy", 32'(rx_busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idleLine(1'b1, 20);

      // Single byte plus latency from the start edge to rx_valid (about 9.5 bit times).
      expectByte(8'hA5);
      applyStimulus(8'hA5, 1'b1, -1, -1, -1);
      waitDrain();
      checkOutput("latency_window", 32'(latency >= 1515 && latency <= 1550), 32'd1);
      checkOutput("no_ferr_a5", 32'(fe_seen), 32'd0);

      // Back-to-back frames with no idle gap.
      expectByte(8'h03);
      applyStimulus(8'h03, 1'b1, -1, -1, -1);
      expectByte(8'h7F);
      applyStimulus(8'h7F, 1'b1, -1, -1, -1);
      expectByte(8'h00);
      applyStimulus(8'h00, 1'b1, -1, -1, -1);
      waitDrain();
      checkOutput("b2b_count", 32'(valid_seen), 32'd4);

      // Short low glitch: start seen, then rejected as a false start.
      idleLine(1'b1, 20);
      idleLine(1'b0, 20);
      checkOutput("glitch_busy", 32'(rx_busy), 32'd1);
      idleLine(1'b0, 27);
      idleLine(1'b1, 200);
      checkOutput("false_start_busy", 32'(rx_busy), 32'd0);
      checkOutput("false_start_data", 32'(rx_data), 32'(last_byte));
      checkOutput("false_start_count", 32'(valid_seen), 32'd4);

      // Stop bit low, then line held low: one frame_error, no restart until the line rises.
      exp_fe++;
      applyStimulus(8'h55, 1'b0, -1, -1, -1);
      idleLine(1'b0, 5 * BIT_CYCLES);
      checkOutput("wait_idle_busy", 32'(rx_busy), 32'd0);
      checkOutput("ferr_once", 32'(fe_seen), 32'd1);
      checkOutput("ferr_data_kept", 32'(rx_data), 32'(last_byte));
      idleLine(1'b1, 100);
      expectByte(8'h11);
      applyStimulus(8'h11, 1'b1, -1, -1, -1);
      waitDrain();

      // One-cycle glitch landing on the middle vote sample of data bit 3.
      expectByte(8'h0F);
      applyStimulus(8'h0F, 1'b1, 730, -1, -1);
      waitDrain();

      // Receiver disabled for a whole frame.
      idleLine(1'b1, 50);
      rx_enable = 1'b0;
      applyStimulus(8'hC3, 1'b1, -1, -1, -1);
      idleLine(1'b1, 50);
      checkOutput("disabled_count", 32'(valid_seen), 32'(exp_valid));
      rx_enable = 1'b1;
      idleLine(1'b1, 50);

      // rx_enable dropped at data bit 4: frame runs out, byte discarded.
      applyStimulus(8'h3C, 1'b1, -1, 5 * BIT_CYCLES + 40, -1);
      idleLine(1'b1, 50);
      checkOutput("drop_count", 32'(valid_seen), 32'(exp_valid));
      checkOutput("drop_data_kept", 32'(rx_data), 32'(last_byte));
      rx_enable = 1'b1;
      idleLine(1'b1, 50);

      // Reset in data bit 2 (line high there), then a normal frame.
      applyStimulus(8'hFC, 1'b1, -1, -1, 3 * BIT_CYCLES + 40);
      idleLine(1'b1, 200);
      expectByte(8'h81);
      applyStimulus(8'h81, 1'b1, -1, -1, -1);
      waitDrain();

      idleLine(1'b1, 50);
      checkOutput("valid_total", 32'(valid_seen), 32'(exp_valid));
      checkOutput("ferr_total", 32'(fe_seen), 32'(exp_fe));

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
